// File: rtl/s2p.sv
// s2p: serial-to-parallel deserializer, LSB-first 1-bit valid/ready stream in,
// N-bit valid/ready words out. A shift register collects the next word while
// the output register holds the previous one, so the serial side stalls only
// when both hold complete words.
// Optional feature: define S2P_PARITY_EN to expect one even-parity bit after
// the N data bits of every frame and to report mismatches on p_err.
module s2p #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    input  logic         p_ready
`ifdef S2P_PARITY_EN
    ,
    output logic         p_err
`endif
);

`ifdef S2P_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif
    localparam int            CW   = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        WAIT    = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  out_reg;
    logic [N-1:0]  word_c;
    logic          last_bit;
    logic          slot_free;

`ifdef S2P_PARITY_EN
    logic par_acc;   // running XOR of the data bits of the current frame
    logic pend_err;  // parity result of the word parked in shift_reg
    logic err_reg;
    logic err_c;

    // The parity bit completes the frame; the data bits are already in place.
    assign word_c = shift_reg;
    assign err_c  = par_acc ^ s_data;
    assign p_err  = err_reg;
`else
    // The last data bit completes the word on the edge it is accepted.
    assign word_c = {s_data, shift_reg[N-1:1]};
`endif

    assign s_ready   = (state == COLLECT) && !rst;
    assign p_data    = out_reg;
    assign last_bit  = (count == LAST);
    assign slot_free = !p_valid || p_ready;

    // Collect serial bits, hand complete words to the output register, park
    // one word in the shift register while the output slot is occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            count     <= '0;
            shift_reg <= '0;
            out_reg   <= '0;
            p_valid   <= 1'b0;
`ifdef S2P_PARITY_EN
            par_acc   <= 1'b0;
            pend_err  <= 1'b0;
            err_reg   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments only; the later assignment to
            // p_valid below overrides this drain default when a word loads.
            if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
            case (state)
                COLLECT: begin
                    if (s_valid) begin
                        if (last_bit) begin
                            count <= '0;
`ifdef S2P_PARITY_EN
                            par_acc <= 1'b0;
`endif
                            if (slot_free) begin
                                out_reg <= word_c;
                                p_valid <= 1'b1;
`ifdef S2P_PARITY_EN
                                err_reg <= err_c;
`endif
                            end else begin
                                shift_reg <= word_c;
`ifdef S2P_PARITY_EN
                                pend_err  <= err_c;
`endif
                                state     <= WAIT;
                            end
                        end else begin
                            shift_reg <= {s_data, shift_reg[N-1:1]};
                            count     <= count + CW'(1);
`ifdef S2P_PARITY_EN
                            par_acc   <= par_acc ^ s_data;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (p_ready) begin
                        out_reg <= shift_reg;
                        p_valid <= 1'b1;
`ifdef S2P_PARITY_EN
                        err_reg <= pend_err;
`endif
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_s2p.sv
// tb_s2p: self-checking bench for s2p. A word-level model (bit list of the
// current frame, queue of undelivered words) predicts s_ready, p_valid,
// p_data and p_err every cycle; directed steps follow the block's scenarios,
// then a randomized phase exercises arbitrary valid/ready patterns.
module tb_s2p;

    localparam int N = 8;
`ifdef S2P_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic         clk;
    logic         rst;
    logic         s_data;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
`ifdef S2P_PARITY_EN
    logic         p_err;
`endif

    s2p #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .p_data  (p_data),
        .p_valid (p_valid),
        .p_ready (p_ready)
`ifdef S2P_PARITY_EN
        ,
        .p_err   (p_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: bits of the frame being received, and the
    // complete words not yet delivered (at most two can be held).
    bit           cur[$];
    logic [N-1:0] exp_d[$];
    logic         exp_e[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A finished frame becomes a word: bit i of the word is the i-th bit received.
    task automatic complete_frame();
        logic [N-1:0] w;
        logic         e;
        w = '0;
        for (int i = 0; i < N; i++) w[i] = cur[i];
        e = 1'b0;
`ifdef S2P_PARITY_EN
        e = ((^w) != cur[N]);
`endif
        exp_d.push_back(w);
        exp_e.push_back(e);
        cur.delete();
    endtask

    // One clock cycle: drive, check outputs against the model, clock, update model.
    task automatic cycle(input logic sv, input logic sd, input logic pr);
        bit take;
        bit drain;
        s_valid = sv;
        s_data  = sd;
        p_ready = pr;
        #3;
        check("s_ready", 32'(s_ready), 32'(exp_d.size() < 2));
        check("p_valid", 32'(p_valid), 32'(exp_d.size() > 0));
        if (exp_d.size() > 0) begin
            check("p_data", 32'(p_data), 32'(exp_d[0]));
`ifdef S2P_PARITY_EN
            check("p_err", 32'(p_err), 32'(exp_e[0]));
`endif
        end
        take  = sv && (exp_d.size() < 2);
        drain = pr && (exp_d.size() > 0);
        @(posedge clk);
        #1;
        if (drain) begin
            void'(exp_d.pop_front());
            void'(exp_e.pop_front());
        end
        if (take) begin
            cur.push_back(sd);
            if (cur.size() == FRAME) complete_frame();
        end
    endtask

    // Hold reset for n cycles with s_valid high; everything must read as reset.
    task automatic rst_cycles(input int n);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 1'b1;
        p_ready = 1'b0;
        cur.delete();
        exp_d.delete();
        exp_e.delete();
        for (int i = 0; i < n; i++) begin
            #3;
            check("rst_s_ready", 32'(s_ready), 32'd0);
            check("rst_p_valid", 32'(p_valid), 32'd0);
            check("rst_p_data", 32'(p_data), 32'h00);
`ifdef S2P_PARITY_EN
            check("rst_p_err", 32'(p_err), 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Send one frame back to back; pr_last is p_ready on the final bit.
    // bad=1 inverts the parity bit when parity is enabled.
    task automatic send_frame(input logic [N-1:0] w, input bit bad,
                              input logic pr_body, input logic pr_last);
        for (int i = 0; i < FRAME; i++) begin
            logic b;
            if (i < N) b = w[i];
            else       b = (^w) ^ bad;
            cycle(1'b1, b, (i == FRAME - 1) ? pr_last : pr_body);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 1'b0;
        p_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with s_valid high, then released.
        rst_cycles(3);
        cycle(1'b0, 1'b0, 1'b1);

        // Single word 8'h3E with p_ready high; p_valid for one cycle only.
        send_frame(8'h3E, 1'b0, 1'b1, 1'b1);
        check("single_p_data", 32'(p_data), 32'h3E);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);

        // Gap of three idle cycles after the fourth bit of 8'h34.
        for (int i = 0; i < FRAME; i++) begin
            logic [N-1:0] w;
            w = 8'h34;
            if (i == 4) repeat (3) cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b1, (i < N) ? w[i] : ^w, 1'b1);
        end
        check("gap_p_data", 32'(p_data), 32'h34);
        cycle(1'b0, 1'b0, 1'b1);

        // Back-pressure: two words with p_ready low, serial side must stall.
        send_frame(8'h3E, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        check("bp_stall", 32'(s_ready), 32'd0);
        check("bp_hold", 32'(p_data), 32'h3E);
        cycle(1'b0, 1'b0, 1'b1);
        check("bp_second", 32'(p_data), 32'h34);
        check("bp_resume", 32'(s_ready), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);

        // Simultaneous completion of 8'hA5 and drain of held 8'h3E.
        send_frame(8'h3E, 1'b0, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("sim_p_data", 32'(p_data), 32'hA5);
        check("sim_p_valid", 32'(p_valid), 32'd1);
        check("sim_no_wait", 32'(s_ready), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);

        // Reset mid-word: partial 8'h3E discarded, then 8'hA5 delivered.
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] w;
            w = 8'h3E;
            cycle(1'b1, w[i], 1'b1);
        end
        rst_cycles(1);
        cycle(1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        check("rstmid_p_data", 32'(p_data), 32'hA5);
        cycle(1'b0, 1'b0, 1'b1);

`ifdef S2P_PARITY_EN
        // 8'hA5 has even weight: parity bit 1 is an error, 0 is not.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        check("par_err1", 32'(p_err), 32'd1);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        check("par_err0", 32'(p_err), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);
`endif

        // Randomized valid/ready traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 1) == 1));
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel deserializer. Sits directly downstream of the team's parallel-to-serial stage.
- Consumes its LSB-first 1-bit valid/ready stream and reassembles N-bit words.
- Presents words on a parallel valid/ready interface.
- Double-buffered: a shift register collects the next word while the output register holds the previous one. The serial side stalls only when both are full.

Parameters:
- N, 8, data word width in bits (N >= 2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_data  input  1  serial data bit; bit 0 of each word arrives first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block can accept a serial bit this cycle.
- p_data  output  N  assembled parallel word (registered).
- p_valid  output  1  p_data holds an undelivered word (registered).
- p_ready  input  1  downstream accepts p_data this cycle.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: p_valid=0, p_data=0, state=COLLECT, count=0, shift_reg=0. s_ready=0 while rst is high.
- Handshakes:
  - Serial bit transfers on an edge with s_valid && s_ready.
  - Word transfers on an edge with p_valid && p_ready.
  - s_ready is combinational from state only (state==COLLECT && !rst); it never depends on s_valid.
  - p_valid must not be withdrawn while p_ready=0. p_data is stable while p_valid && !p_ready.
- Registers:
  - count, width $clog2(N): number of bits collected in the current word.
  - shift_reg[N-1:0]: on each accepted bit, shift_reg <= {s_data, shift_reg[N-1:1]}. After N bits, the first bit received is in bit 0.
  - out_reg drives p_data.
- State COLLECT (s_ready=1):
  - Accepted bit with count<N-1: shift in the bit, count+1.
  - Accepted bit with count==N-1 (word complete), and the output slot is free (p_valid==0, or p_ready==1 this cycle): out_reg <= {s_data, shift_reg[N-1:1]}, p_valid<=1, count<=0, stay in COLLECT.
  - Accepted bit with count==N-1, slot not free: shift in the bit, count<=0, go to WAIT.
  - No accepted bit: count and shift_reg hold.
- State WAIT (s_ready=0): a complete word sits in shift_reg.
  - When p_ready==1: out_reg <= shift_reg, p_valid stays 1, go to COLLECT.
  - Otherwise hold.
- p_valid clears on a word transfer if no new word loads on the same edge.
- Latency: the word appears on p_data/p_valid on the edge that accepts its last bit, i.e. 1 cycle after the last bit is presented.
- Throughput: with p_ready=1 continuously, one word per N accepted bits, no serial stall.
- Simultaneous completion and drain: if a word completes on the same edge that drains the output, the new word loads directly and p_valid stays high with no bubble.
- count wraps N-1 -> 0 only on word completion; it never reaches N.
- Reset mid-operation: partial word and pending output words are discarded, all state returns to reset values. No word is emitted for a partial frame.

Optional Feature:
- Macro S2P_PARITY_EN.
- Defined:
  - Each serial frame is N data bits followed by 1 even-parity bit; count widens to range 0..N.
  - The parity bit is accepted like a data bit, and the word completes on it.
  - Adds output port p_err (1 bit, registered with p_data, reset 0): 1 when the XOR of the N data bits differs from the parity bit.
  - The word is delivered regardless of p_err.
- Undefined: no p_err port, frame is exactly N bits, behaviour as above.

Test Plan:
- Reset: hold rst high 3 cycles with s_valid=1 -> s_ready=0, p_valid=0, p_data=8'h00. One cycle after release, s_ready=1.
- Single word: p_ready=1, send bits 0,1,1,1,1,1,0,0 (8'd62) on consecutive cycles -> p_valid=1 exactly after the 8th accepting edge, p_data=8'h3E, p_valid=0 next cycle.
- Gaps: send 8'd52 (bits 0,0,1,0,1,1,0,0) with s_valid=0 for 3 cycles after bit 3 -> count holds, p_data=8'h34, p_valid for 1 cycle.
- Back-pressure: p_ready=0, send 8'h3E then 8'h34 -> after the 16th bit, s_ready=0 (WAIT) and p_data stays 8'h3E. Raise p_ready for one cycle -> 8'h3E transferred, next cycle p_data=8'h34, p_valid=1, s_ready=1.
- Simultaneous: p_valid=1 holding 8'h3E, last bit of 8'hA5 accepted on the same edge p_ready=1 -> no WAIT entered, p_data=8'hA5, p_valid continuously high.
- Reset mid-word: after 4 bits of 8'h3E assert rst for 1 cycle, then send 8'hA5 -> p_data=8'hA5, no partial word emitted. With S2P_PARITY_EN: 8'hA5 plus parity bit 1 -> p_err=1; plus parity bit 0 -> p_err=0.
